h_arb_mux: RTL
==============

H_ARB_MUX -- requirements
Module: h_arb_mux

Interface
REQ-001 Parameter WIDTH, default 16: data bits per way.
REQ-002 Parameter WAYS, default 4: number of input ways; power of two, 2..16.
REQ-003 Parameter SELW, default 2: select width; equals log2(WAYS).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
REQ-007 sel  input  SELW  way select, used in mode 0 only.
REQ-008 in_data  input  WAYS*WIDTH  packed way data; way i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  WAYS  per-way valid.
REQ-010 in_ready  output  WAYS  per-way ready; combinational.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_sel  output  SELW  registered index of the way that supplied out_data.

Function
REQ-015 load_en SHALL be (!out_valid || out_ready).
REQ-016 Mode 0: candidate = sel; grant to way sel iff in_valid[sel] && load_en; other ways never granted.
REQ-017 Mode 1: candidate = first asserted in_valid bit searching from internal pointer ptr upward, wrapping WAYS-1 -> 0; grant iff any in_valid && load_en.
REQ-018 ptr SHALL update to (granted index + 1) mod WAYS on each mode-1 grant; hold otherwise, including all of mode 0.
REQ-019 in_ready[i] SHALL be 1 only for the granted way in that cycle; at most one bit set; all zero when no grant.
REQ-020 A transfer on way i occurs when in_valid[i] && in_ready[i]; on that edge out_data <= way i word, out_sel <= i, out_valid <= 1.
REQ-021 Latency: input word appears on out_data exactly 1 cycle after transfer; throughput 1 word/cycle when out_ready held 1.
REQ-022 No transfer and out_ready=1: out_valid <= 0; out_data, out_sel hold last value.
REQ-023 out_valid=1 and out_ready=0: out_data, out_sel, out_valid SHALL hold stable; in_ready all zero (backpressure).
REQ-024 Simultaneous downstream accept and new transfer in same cycle: new word loads, out_valid stays 1, no bubble.
REQ-025 Mode or sel change takes effect on the next cycle's combinational grant; a held output word is unaffected.
REQ-026 Mode 1 fairness: with all ways continuously valid and out_ready=1, grants SHALL cycle 0,1,...,WAYS-1,0,... .
REQ-027 in_valid deasserted on a way with held output word: no effect on held word.

Reset
REQ-028 While reset=1 at an edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-029 in_ready SHALL be all zero in any cycle with reset=1, regardless of mode or in_valid.
REQ-030 Reset mid-operation discards any held output word; no transfer is counted in a reset cycle.

Verification
REQ-031 Reset: reset=1 two cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0x0000, out_sel=0.
REQ-032 Mode 0: sel=2, in_valid=0100, way2=0xBEEF, out_ready=1 -> in_ready=0100; next cycle out_data=0xBEEF, out_sel=2, out_valid=1.
REQ-033 Mode 1 rotation: in_valid=1111, ways 0xA000..0xA003, out_ready=1 for 6 cycles -> out_sel sequence 0,1,2,3,0,1, no bubbles.
REQ-034 Wrap/skip: ptr=3 after grant to way 2, in_valid=0010 -> grant way 1; next grant search starts at 2.
REQ-035 Backpressure: out_valid=1 holding 0x1234, out_ready=0 for 3 cycles with in_valid=1111 -> out_data stays 0x1234, in_ready=0000; out_ready=1 -> next word loads same edge as accept.
REQ-036 Reset mid-stream: reset pulse while out_valid=1 -> next cycle out_valid=0, then mode-1 grants restart at way 0.

Source files
------------

// File: rtl/h_arb_mux.sv
// Registered WAYS-to-1 data mux with fixed-select or round-robin arbitration
// and a single output register under valid/ready flow control.
module h_arb_mux #(
    parameter int WIDTH = 16,
    parameter int WAYS  = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [WAYS*WIDTH-1:0] in_data,
    input  logic [WAYS-1:0]       in_valid,
    output logic [WAYS-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_sel
);

    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [SELW-1:0]  out_sel_q;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             found;
    logic             grant;
    logic [SELW-1:0]  cand;
    logic [SELW-1:0]  idx;
    logic [WIDTH-1:0] cand_word;

    assign load_en = !out_valid_q || out_ready;

    // Round-robin search starts at ptr; SELW-bit addition wraps WAYS-1 -> 0.
    always_comb begin
        cand  = sel;
        found = in_valid[sel];
        idx   = '0;
        if (mode) begin
            cand  = '0;
            found = 1'b0;
            for (int unsigned k = 0; k < WAYS; k++) begin
                idx = ptr_q + SELW'(k);
                if (!found && in_valid[idx]) begin
                    found = 1'b1;
                    cand  = idx;
                end
            end
        end
    end

    assign grant     = found && load_en && !reset;
    assign cand_word = in_data[cand*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (grant) in_ready[cand] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant && mode) ptr_d = cand + SELW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (grant) begin
                out_data_q  <= cand_word;
                out_sel_q   <= cand;
                out_valid_q <= 1'b1;
            end else if (load_en) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

endmodule
